// File: rtl/ex_mem_pipe.sv
// EX/MEM elastic pipeline stage: a 2-entry skid buffer with valid/ready on both sides,
// synchronous flush, and memory / write-back control decode from the head entry.
// in_ready_o comes from a flop, so MEM back-pressure never forms a combinational path
// into EX.

module ex_mem_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] inst_i,
  input  logic [DATA_WIDTH-1:0] alu_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] alu_o,
  output logic [DATA_WIDTH-1:0] rs2_o,
  output logic                  mem_wren_o,
  output logic                  mem_rden_o,
  output logic [1:0]            wb_sel_o,
  output logic                  rd_wren_o,
  output logic [4:0]            rd_addr_o,
  output logic [BE_WIDTH-1:0]   byte_en_o,
  output logic                  misalign_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] rs2;
  } entry_t;

  // Occupancy count doubles as the state encoding.
  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  localparam logic [4:0] OpLoad  = 5'b00000;
  localparam logic [4:0] OpStore = 5'b01000;

  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       in_ready_q, in_ready_d;
  entry_t     in_entry;
  logic       push, pop;

  assign in_entry = '{pc: pc_i, inst: inst_i, alu: alu_i, rs2: rs2_i};

  assign out_valid_o = (count_q != StEmpty);
  assign in_ready_o  = in_ready_q;
  assign push        = in_valid_i & in_ready_q;
  assign pop         = out_valid_o & out_ready_i;

  // Next occupancy and storage; head always holds the oldest entry.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = StEmpty;
    end else begin
      case (count_q)
        StEmpty: begin
          if (push) begin
            head_d  = in_entry;
            count_d = StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            tail_d  = in_entry;
            count_d = StFull;
          end else if (pop) begin
            count_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = StOne;
          end
        end
        default: count_d = StEmpty;
      endcase
    end
    // Ready is registered from the next occupancy, so it never depends on out_ready_i
    // within a cycle.
    in_ready_d = (count_d != StFull);
  end

  // State and storage registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= StEmpty;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign pc_o      = head_q.pc;
  assign inst_o    = head_q.inst;
  assign alu_o     = head_q.alu;
  assign rs2_o     = head_q.rs2;
  assign rd_addr_o = head_q.inst[11:7];

  logic [4:0] op;
  logic [1:0] f3_lo;
  logic [1:0] alu_lo;
  logic       is_load, is_store, is_mem;
  logic [3:0] be_lo;

  assign op     = head_q.inst[6:2];
  assign f3_lo  = head_q.inst[13:12];
  assign alu_lo = head_q.alu[1:0];

  // Control decode of the head entry; everything goes inactive when the head is empty.
  always_comb begin
    is_load  = out_valid_o && (op == OpLoad);
    is_store = out_valid_o && (op == OpStore);
    is_mem   = is_load || is_store;

    if (!out_valid_o) begin
      wb_sel_o = 2'b11;
    end else begin
      case (op)
        5'b01100, 5'b01101, 5'b00100, 5'b00101: wb_sel_o = 2'b00;
        OpLoad:                                 wb_sel_o = 2'b01;
        5'b11011, 5'b11001:                     wb_sel_o = 2'b10;
        default:                                wb_sel_o = 2'b11;
      endcase
    end

    be_lo = 4'b0000;
    if (is_mem) begin
      case (f3_lo)
        2'b00:   be_lo = 4'b0001 << alu_lo;
        2'b01:   be_lo = alu_lo[1] ? 4'b1100 : 4'b0011;
        2'b10:   be_lo = 4'b1111;
        default: be_lo = 4'b0000;
      endcase
    end
    // Lanes above the low word are never enabled.
    byte_en_o      = '0;
    byte_en_o[3:0] = be_lo;

    misalign_o = is_mem && (((f3_lo == 2'b01) && alu_lo[0]) ||
                            ((f3_lo == 2'b10) && (alu_lo != 2'b00)));
    mem_wren_o = is_store;
    mem_rden_o = is_load;
    rd_wren_o  = out_valid_o && (wb_sel_o != 2'b11) && (rd_addr_o != 5'd0);
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: accepted entries queue their hand-computed expected
// outputs; a negedge monitor pops and compares on every MEM-side transfer.

module tb_ex_mem_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] pc_i, inst_i, alu_i, rs2_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] pc_o, inst_o, alu_o, rs2_o;
  logic        mem_wren_o, mem_rden_o, rd_wren_o, misalign_o;
  logic [1:0]  wb_sel_o;
  logic [4:0]  rd_addr_o;
  logic [3:0]  byte_en_o;

  ex_mem_pipe #(.DATA_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .alu_i       (alu_i),
    .rs2_i       (rs2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .alu_o       (alu_o),
    .rs2_o       (rs2_o),
    .mem_wren_o  (mem_wren_o),
    .mem_rden_o  (mem_rden_o),
    .wb_sel_o    (wb_sel_o),
    .rd_wren_o   (rd_wren_o),
    .rd_addr_o   (rd_addr_o),
    .byte_en_o   (byte_en_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc, inst, alu, rs2;
    logic        wren, rden;
    logic [1:0]  wb;
    logic        rdw;
    logic [4:0]  rd;
    logic [3:0]  be;
    logic        mis;
  } vec_t;

  vec_t vecs [0:7];
  vec_t cur_vec;
  vec_t exp_v;
  vec_t sb_q [$];
  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: compare on pop, then enqueue on push; flush/reset discard the queue.
  always @(negedge clk_i) begin
    if (rst_i || flush_i) begin
      sb_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual_inst=%h expected=none", inst_o);
        end else begin
          exp_v = sb_q.pop_front();
          pops++;
          check("pc", pc_o, exp_v.pc);
          check("inst", inst_o, exp_v.inst);
          check("alu", alu_o, exp_v.alu);
          check("rs2", rs2_o, exp_v.rs2);
          check("mem_wren", {31'd0, mem_wren_o}, {31'd0, exp_v.wren});
          check("mem_rden", {31'd0, mem_rden_o}, {31'd0, exp_v.rden});
          check("wb_sel", {30'd0, wb_sel_o}, {30'd0, exp_v.wb});
          check("rd_wren", {31'd0, rd_wren_o}, {31'd0, exp_v.rdw});
          check("rd_addr", {27'd0, rd_addr_o}, {27'd0, exp_v.rd});
          check("byte_en", {28'd0, byte_en_o}, {28'd0, exp_v.be});
          check("misalign", {31'd0, misalign_o}, {31'd0, exp_v.mis});
        end
      end
      if (in_valid_i && in_ready_o) sb_q.push_back(cur_vec);
    end
  end

  task automatic drive(input int idx);
    cur_vec = vecs[idx];
    pc_i    = vecs[idx].pc;
    inst_i  = vecs[idx].inst;
    alu_i   = vecs[idx].alu;
    rs2_i   = vecs[idx].rs2;
  endtask

  // Present one entry and hold it until accepted (bounded).
  task automatic send(input int idx);
    int waited;
    waited = 0;
    drive(idx);
    in_valid_i = 1'b1;
    while (!in_ready_o && waited < 50) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (!in_ready_o) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted idx=%0d", idx);
    end else begin
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb_q.size() != 0 || in_valid_i) && waited < 60) begin
      @(posedge clk_i); #1;
      waited++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual_pending=%0d expected=0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             pc            inst          alu           rs2           wr  rd  wb     rdw rd     be       mis
    vecs[0] = '{32'h100, 32'h00112423, 32'h104, 32'hDEADBEEF, 1, 0, 2'b11, 0, 5'd8, 4'b1111, 0}; // sw
    vecs[1] = '{32'h104, 32'h002082B3, 32'h030, 32'h00000011, 0, 0, 2'b00, 1, 5'd5, 4'b0000, 0}; // add
    vecs[2] = '{32'h108, 32'h0000A303, 32'h200, 32'h0,        0, 1, 2'b01, 1, 5'd6, 4'b1111, 0}; // lw
    vecs[3] = '{32'h10C, 32'h008000EF, 32'h114, 32'h0,        0, 0, 2'b10, 1, 5'd1, 4'b0000, 0}; // jal
    vecs[4] = '{32'h110, 32'h00009383, 32'h103, 32'h0,        0, 1, 2'b01, 1, 5'd7, 4'b1100, 1}; // lh
    vecs[5] = '{32'h114, 32'h00208023, 32'h102, 32'h000000AB, 1, 0, 2'b11, 0, 5'd0, 4'b0100, 0}; // sb
    vecs[6] = '{32'h118, 32'h00000013, 32'h0,   32'h0,        0, 0, 2'b00, 0, 5'd0, 4'b0000, 0}; // nop
    vecs[7] = '{32'hBAD, 32'h002082B3, 32'h777, 32'h777,      0, 0, 2'b00, 1, 5'd5, 4'b0000, 0}; // dropped

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    pc_i = '0; inst_i = '0; alu_i = '0; rs2_i = '0;
    #2;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst_wb_sel", {30'd0, wb_sel_o}, 32'd3);
    check("rst_byte_en", {28'd0, byte_en_o}, 32'd0);
    #10 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // sw into an empty stage: visible the next cycle.
    out_ready_i = 1'b1;
    send(0);
    check("sw_latency_valid", {31'd0, out_valid_o}, 32'd1);
    check("sw_wren", {31'd0, mem_wren_o}, 32'd1);
    drain();

    // Back-pressure: two accepted, third held, then released in order.
    out_ready_i = 1'b0;
    send(1);
    send(2);
    check("full_in_ready", {31'd0, in_ready_o}, 32'd0);
    fork
      send(3);
    join_none
    repeat (3) @(posedge clk_i);
    #1;
    check("held_in_valid", {31'd0, in_valid_i}, 32'd1);
    check("held_head_inst", inst_o, vecs[1].inst);
    out_ready_i = 1'b1;
    drain();

    // lh at 0x103 alone at head, then simultaneous push/pop at count 1.
    send(4);
    check("lh_misalign", {31'd0, misalign_o}, 32'd1);
    check("lh_byte_en", {28'd0, byte_en_o}, 32'hC);
    check("lh_wb_sel", {30'd0, wb_sel_o}, 32'd1);
    send(5);
    check("pushpop_head", inst_o, vecs[5].inst);
    check("pushpop_in_ready", {31'd0, in_ready_o}, 32'd1);
    drain();

    // Flush at count 2 with a coincident push.
    out_ready_i = 1'b0;
    send(6);
    send(0);
    drive(7);
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    @(posedge clk_i); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready_o}, 32'd1);
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("flush_stays_empty", {31'd0, out_valid_o}, 32'd0);

    // Asynchronous reset mid-cycle with the buffer full.
    out_ready_i = 1'b0;
    send(1);
    send(2);
    check("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("midrst_wb_sel", {30'd0, wb_sel_o}, 32'd3);
    check("midrst_pc_cleared", pc_o, 32'd0);
    #8 rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("post_rst_valid", {31'd0, out_valid_o}, 32'd0);
    out_ready_i = 1'b1;
    send(6);
    drain();

    repeat (2) @(posedge clk_i);
    #1;
    check("total_pops", pops, 32'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
